// File: rtl/nebula_local_inject_arbiter_if.sv
// rtl/nebula_local_inject_arbiter_if.sv - requester-side and router-side flit handshakes
interface nebula_local_inject_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int FLIT_W  = 34
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           out_valid;
    logic [FLIT_W-1:0]              out_flit;
    logic                           out_ready;

    modport master (
        output req_valid, req_flit, out_ready,
        input  req_ready, out_valid, out_flit
    );

    modport slave (
        input  req_valid, req_flit, out_ready,
        output req_ready, out_valid, out_flit
    );
endinterface

// File: rtl/nebula_local_inject_arbiter.sv
// rtl/nebula_local_inject_arbiter.sv - packet-level round-robin arbiter onto one mesh local injection port
module nebula_local_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int STALL_LIMIT = 256,
    parameter int CNT_WIDTH   = 16,
    parameter int FLIT_W      = 34,
    parameter int OW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nebula_local_inject_arbiter_if.slave bus,
    output logic [OW-1:0]                owner,
    output logic                         locked,
    output logic [CNT_WIDTH-1:0]         pkt_count,
    output logic                         stall_err,
    output logic                         proto_err,
    input  logic                         err_clr
);
    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);

    // Flit type lives in the two MSBs of every flit.
    localparam logic [1:0] FLIT_TYPE_HEAD   = 2'b00;
    localparam logic [1:0] FLIT_TYPE_BODY   = 2'b01;
    localparam logic [1:0] FLIT_TYPE_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [OW-1:0]   rr_ptr;
    logic [SW-1:0]   stall_cnt;
    logic [OW-1:0]   grant;
    logic            grant_ok;
    logic            proto_evt;
    logic            acc;
    logic            take;
    logic [1:0]      take_type;
    logic            stall_idle;
    logic            stall_hit;

    function automatic logic is_start(input logic [1:0] ft);
        return (ft == FLIT_TYPE_HEAD) || (ft == FLIT_TYPE_SINGLE);
    endfunction

    function automatic logic [OW-1:0] rr_index(input logic [OW-1:0] base, input int offset);
        int s;
        s = (int'(base) + offset) % NUM_REQ;
        return OW'(s);
    endfunction

    always_comb begin
        grant     = owner;
        grant_ok  = 1'b0;
        proto_evt = 1'b0;
        if (state == ST_IDLE) begin
            // Descending scan: the eligible requester closest to rr_ptr is written last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[rr_index(rr_ptr, k)] &&
                    is_start(bus.req_flit[rr_index(rr_ptr, k)][FLIT_W-1 -: 2])) begin
                    grant    = rr_index(rr_ptr, k);
                    grant_ok = 1'b1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && !is_start(bus.req_flit[i][FLIT_W-1 -: 2])) begin
                    proto_evt = 1'b1;
                end
            end
        end else if (bus.req_valid[owner]) begin
            if (is_start(bus.req_flit[owner][FLIT_W-1 -: 2])) begin
                proto_evt = 1'b1;
            end else begin
                grant_ok = 1'b1;
            end
        end
    end

    assign acc        = ~bus.out_valid | bus.out_ready;
    assign take       = acc & grant_ok;
    assign take_type  = bus.req_flit[grant][FLIT_W-1 -: 2];
    assign locked     = (state == ST_LOCKED);
    assign stall_idle = (state == ST_LOCKED) & ~bus.req_valid[owner];
    assign stall_hit  = stall_idle & (stall_cnt == STALL_MAX);

    always_comb begin
        bus.req_ready        = '0;
        bus.req_ready[grant] = take;
    end

    always_comb begin
        state_nx = state;
        if (take) begin
            if (state == ST_IDLE && take_type == FLIT_TYPE_HEAD) begin
                state_nx = ST_LOCKED;
            end else if (state == ST_LOCKED && take_type == FLIT_TYPE_TAIL) begin
                state_nx = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_flit  <= '0;
            owner         <= '0;
            rr_ptr        <= '0;
            pkt_count     <= '0;
            stall_cnt     <= '0;
            stall_err     <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            if (take) begin
                bus.out_flit  <= bus.req_flit[grant];
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (take && state == ST_IDLE) begin
                owner  <= grant;
                rr_ptr <= rr_index(grant, 1);
            end
            if (take && (take_type == FLIT_TYPE_SINGLE || take_type == FLIT_TYPE_TAIL)) begin
                pkt_count <= pkt_count + 1'b1;
            end
            // The lock is kept on a stall; the counter just parks at its limit.
            if (state != ST_LOCKED || take) begin
                stall_cnt <= '0;
            end else if (stall_idle && !stall_hit) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            stall_err <= stall_hit | (stall_err & ~err_clr);
            proto_err <= proto_evt | (proto_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_nebula_local_inject_arbiter.sv
// tb/tb_nebula_local_inject_arbiter.sv - randomized and directed bench for the local inject arbiter
module tb_nebula_local_inject_arbiter;
    localparam int N  = 4;
    localparam int SL = 16;
    localparam int CW = 4;
    localparam int FW = 34;
    localparam int OW = 2;
    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_BODY   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err_clr = 1'b0;
    logic [OW-1:0] owner;
    logic          locked;
    logic [CW-1:0] pkt_count;
    logic          stall_err;
    logic          proto_err;

    nebula_local_inject_arbiter_if #(.NUM_REQ(N), .FLIT_W(FW)) bus ();

    nebula_local_inject_arbiter #(
        .NUM_REQ(N), .STALL_LIMIT(SL), .CNT_WIDTH(CW), .FLIT_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .owner(owner), .locked(locked),
        .pkt_count(pkt_count), .stall_err(stall_err), .proto_err(proto_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int src, input int seq);
        return {t, 4'(src), 28'(seq)};
    endfunction

    // Sources: one flit queue per requester, presented with random gaps.
    logic [FW-1:0] src_q [N][$];
    logic [FW-1:0] acc_log [$];
    logic [FW-1:0] del_log [$];
    logic [N-1:0]  rdy_seen = '0;
    int            valid_pct = 100;
    int            ready_pct = 100;
    int            lock_cycles = 0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (rdy_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        rdy_seen = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                bus.req_valid[i] = 1'b1;
                bus.req_flit[i]  = src_q[i][0];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_flit[i]  = '0;
            end
        end
        bus.out_ready = ($urandom_range(99) < ready_pct);
    end

    // Reference model: packet-level view of the port.
    bit            m_lock;
    int            m_owner, m_rr, m_pkt, m_idle;
    bit            m_serr, m_perr, m_ov;
    logic [FW-1:0] m_of;

    function automatic void model_reset();
        m_lock = 0; m_owner = 0; m_rr = 0; m_pkt = 0; m_idle = 0;
        m_serr = 0; m_perr = 0; m_ov = 0; m_of = '0;
    endfunction

    always @(negedge clk) begin
        int            g;
        bit            pe, acc_ok, take, sset;
        logic [N-1:0]  er;
        logic [1:0]    t;
        if (!rst_n) model_reset();
        g = -1; pe = 0;
        if (!m_lock) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (bus.req_valid[i]) begin
                    t = bus.req_flit[i][FW-1 -: 2];
                    if (t == T_HEAD || t == T_SINGLE) begin
                        if (g < 0) g = i;
                    end else pe = 1;
                end
            end
        end else if (bus.req_valid[m_owner]) begin
            t = bus.req_flit[m_owner][FW-1 -: 2];
            if (t == T_BODY || t == T_TAIL) g = m_owner;
            else pe = 1;
        end
        acc_ok = !m_ov || bus.out_ready;
        take   = (g >= 0) && acc_ok && rst_n;
        er     = take ? N'(1 << g) : '0;

        chk("req_ready", bus.req_ready, er);
        chk("out_valid", bus.out_valid, m_ov);
        chk("out_flit", bus.out_flit, m_of);
        chk("owner", owner, m_owner);
        chk("locked", locked, m_lock);
        chk("pkt_count", pkt_count, m_pkt);
        chk("stall_err", stall_err, m_serr);
        chk("proto_err", proto_err, m_perr);

        for (int i = 0; i < N; i++) if (bus.req_ready[i]) acc_log.push_back(bus.req_flit[i]);
        if (bus.out_valid && bus.out_ready && rst_n) del_log.push_back(bus.out_flit);
        if (locked) lock_cycles++;
        rdy_seen = bus.req_ready;

        if (rst_n) begin
            sset = 0;
            if (m_lock && !take && !bus.req_valid[m_owner]) begin
                m_idle++;
                if (m_idle >= SL) sset = 1;
            end
            if (take) m_idle = 0;
            if (take) begin
                m_of = bus.req_flit[g];
                m_ov = 1;
                t = m_of[FW-1 -: 2];
                if (!m_lock) begin
                    m_owner = g;
                    m_rr = (g + 1) % N;
                    if (t == T_HEAD) m_lock = 1;
                    else m_pkt = (m_pkt + 1) % (1 << CW);
                end else if (t == T_TAIL) begin
                    m_lock = 0;
                    m_pkt = (m_pkt + 1) % (1 << CW);
                end
            end else if (bus.out_ready) m_ov = 0;
            if (!m_lock) m_idle = 0;
            m_serr = sset | (m_serr & !err_clr);
            m_perr = pe | (m_perr & !err_clr);
        end
    end

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic push(input int i, input logic [1:0] t, input int seq);
        src_q[i].push_back(mk(t, i, seq));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #2;
            done = queues_empty() && !bus.out_valid;
        end
        chk("drain", done, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        wait_cycles(2);
        rst_n = 1;
    endtask

    logic [1:0] bp_types [5] = '{T_HEAD, T_BODY, T_BODY, T_BODY, T_TAIL};
    logic [FW-1:0] held;
    int seqs [N];
    int total;

    initial begin
        bus.req_valid = '0;
        bus.req_flit  = '0;
        bus.out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        wait_cycles(1);
        rst_n = 1;

        // Single source
        acc_log.delete(); del_log.delete();
        push(0, T_SINGLE, 1);
        wait_drain(50);
        chk("single_n", del_log.size(), 1);
        if (del_log.size() > 0) chk("single_flit", del_log[0], mk(T_SINGLE, 0, 1));
        chk("single_pkt", pkt_count, 1);
        chk("single_lock", locked, 0);

        // Fair round-robin from reset
        do_reset();
        acc_log.delete();
        for (int i = 0; i < N; i++) begin push(i, T_SINGLE, 10 * i); push(i, T_SINGLE, 10 * i + 1); end
        wait_drain(100);
        chk("rr_n", acc_log.size(), 8);
        for (int k = 0; k < 8 && k < acc_log.size(); k++) chk("rr_src", acc_log[k][31:28], k % N);
        chk("rr_pkt", pkt_count, 8);

        // Wormhole lock: rr_ptr moved to 1 by a lone req0 packet first
        do_reset();
        push(0, T_SINGLE, 0);
        wait_drain(50);
        acc_log.delete();
        lock_cycles = 0;
        push(1, T_HEAD, 1); push(1, T_BODY, 2); push(1, T_BODY, 3); push(1, T_TAIL, 4);
        push(0, T_SINGLE, 5); push(2, T_SINGLE, 6);
        wait_drain(100);
        chk("worm_n", acc_log.size(), 6);
        if (acc_log.size() == 6) begin
            chk("worm_0", acc_log[0], mk(T_HEAD, 1, 1));
            chk("worm_3", acc_log[3], mk(T_TAIL, 1, 4));
            chk("worm_4", acc_log[4], mk(T_SINGLE, 2, 6));
            chk("worm_5", acc_log[5], mk(T_SINGLE, 0, 5));
        end
        chk("worm_lock_cycles", lock_cycles, 3);

        // Backpressure mid-packet
        del_log.delete();
        for (int k = 0; k < 5; k++) push(2, bp_types[k], k);
        wait_cycles(3);
        ready_pct = 0;
        wait_cycles(2);
        held = bus.out_flit;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold", bus.out_flit, held);
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_valid", bus.out_valid, 1);
        end
        ready_pct = 100;
        wait_drain(100);
        chk("bp_n", del_log.size(), 5);
        for (int k = 0; k < 5 && k < del_log.size(); k++) chk("bp_seq", del_log[k], mk(bp_types[k], 2, k));

        // Watchdog
        do_reset();
        push(3, T_HEAD, 0);
        begin
            int c;
            c = 0;
            do begin @(negedge clk); c++; end while (!locked && c < 20);
            chk("wd_locked", locked, 1);
        end
        repeat (15) @(negedge clk);
        chk("wd_before", stall_err, 0);
        @(negedge clk);
        chk("wd_fire", stall_err, 1);
        chk("wd_lock_kept", locked, 1);
        push(3, T_TAIL, 1);
        wait_drain(50);
        chk("wd_pkt", pkt_count, 1);
        chk("wd_sticky", stall_err, 1);
        err_clr = 1; wait_cycles(1); err_clr = 0;
        chk("wd_clr", stall_err, 0);

        // Protocol error: BODY in IDLE
        acc_log.delete();
        push(0, T_BODY, 0);
        wait_cycles(4);
        chk("pe_set", proto_err, 1);
        chk("pe_never", acc_log.size(), 0);
        err_clr = 1; wait_cycles(1); err_clr = 0;
        chk("pe_set_wins", proto_err, 1);
        src_q[0].delete();
        wait_cycles(1);
        err_clr = 1; wait_cycles(1); err_clr = 0;
        chk("pe_clr", proto_err, 0);

        // Randomized traffic
        do_reset();
        del_log.delete();
        valid_pct = 70; ready_pct = 70;
        total = 0;
        for (int i = 0; i < N; i++) seqs[i] = 0;
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(2) == 0) begin
                    push(i, T_SINGLE, seqs[i]++); total++;
                end else begin
                    int nb;
                    nb = $urandom_range(3);
                    push(i, T_HEAD, seqs[i]++); total++;
                    for (int b = 0; b < nb; b++) begin push(i, T_BODY, seqs[i]++); total++; end
                    push(i, T_TAIL, seqs[i]++); total++;
                end
            end
        end
        wait_drain(20000);
        chk("rand_flits", del_log.size(), total);
        chk("rand_pkt_wrap", pkt_count, (4 * 30) % 16);
        valid_pct = 100; ready_pct = 100;

        // Asynchronous reset mid-packet
        push(1, T_HEAD, 0); push(1, T_BODY, 1); push(1, T_BODY, 2); push(1, T_TAIL, 3);
        wait_cycles(3);
        chk("ar_locked_pre", locked, 1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("ar_locked", locked, 0);
        chk("ar_out_valid", bus.out_valid, 0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        wait_cycles(2);
        rst_n = 1;
        wait_cycles(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
